// File: rtl/goose_motion_ctrl.sv
// goose_motion_ctrl: per-frame position, facing and animation for the goose sprite.
// Inputs: clk, reset (sync, active-high), frame_tick, speed[1:0], spin_req.
// Outputs: goose_x, goose_y, anim_frame, facing_left, spinning.
// All outputs are registered and change only on a frame_tick cycle.
module goose_motion_ctrl #(
   parameter int SCREEN_W    = 640,
   parameter int SPRITE_W    = 64,
   parameter int GROUND_Y    = 352,
   parameter int X_START     = 0,
   parameter int ANIM_DIV    = 8,
   parameter int TURN_FRAMES = 16,
   parameter int SPIN_FRAMES = 32,
   parameter int SPIN_LIFT   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic [1:0] speed,
   input  logic       spin_req,
   output logic [9:0] goose_x,
   output logic [9:0] goose_y,
   output logic [1:0] anim_frame,
   output logic       facing_left,
   output logic       spinning
);

   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int TW = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
   localparam int SW = $clog2(SPIN_FRAMES);

   localparam logic [9:0] X_MAX = 10'(SCREEN_W - SPRITE_W);
   localparam logic [9:0] GY    = 10'(GROUND_Y);
   localparam logic [9:0] GY_UP = 10'(GROUND_Y - 2);
   localparam logic [9:0] GY_SP = 10'(GROUND_Y - SPIN_LIFT);
   localparam logic [9:0] X_RST = 10'(X_START);

   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_FRAMES - 1);
   localparam logic [SW-1:0] SPIN_LAST = SW'(SPIN_FRAMES - 1);

   typedef enum logic [1:0] {
      WALK = 2'd0,
      TURN = 2'd1,
      SPIN = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic [1:0]    anim_q, anim_d;
   logic          face_q, face_d;
   logic          spin_q, spin_d;
   logic          saved_face_q, saved_face_d;
   logic          pend_q, pend_d;
   logic [AW-1:0] anim_cnt_q, anim_cnt_d;
   logic [TW-1:0] turn_cnt_q, turn_cnt_d;
   logic [SW-1:0] spin_cnt_q, spin_cnt_d;

   logic sync1_q, sync2_q, prev_q;
   logic req_edge;
   logic [10:0] nx;

   assign req_edge = sync2_q & ~prev_q;
   assign nx       = {1'b0, x_q} + {9'b0, speed};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= spin_req;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= WALK;
         x_q          <= X_RST;
         y_q          <= GY;
         anim_q       <= 2'd0;
         face_q       <= 1'b0;
         spin_q       <= 1'b0;
         saved_face_q <= 1'b0;
         pend_q       <= 1'b0;
         anim_cnt_q   <= '0;
         turn_cnt_q   <= '0;
         spin_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         anim_q       <= anim_d;
         face_q       <= face_d;
         spin_q       <= spin_d;
         saved_face_q <= saved_face_d;
         pend_q       <= pend_d;
         anim_cnt_q   <= anim_cnt_d;
         turn_cnt_q   <= turn_cnt_d;
         spin_cnt_q   <= spin_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      anim_d       = anim_q;
      face_d       = face_q;
      spin_d       = spin_q;
      saved_face_d = saved_face_q;
      pend_d       = pend_q;
      anim_cnt_d   = anim_cnt_q;
      turn_cnt_d   = turn_cnt_q;
      spin_cnt_d   = spin_cnt_q;

      // Edges are dropped while spinning; a tick's own action overrides this.
      if (req_edge && state_q != SPIN) pend_d = 1'b1;

      if (frame_tick) begin
         unique case (state_q)
            WALK: begin
               if (pend_q) begin
                  state_d      = SPIN;
                  pend_d       = 1'b0;
                  saved_face_d = face_q;
                  spin_cnt_d   = '0;
                  spin_d       = 1'b1;
                  y_d          = GY_SP;
                  anim_d       = 2'd0;
               end else if (speed == 2'd0) begin
                  anim_d = 2'd0;
                  y_d    = GY;
               end else begin
                  if (anim_cnt_q == ANIM_LAST) begin
                     anim_cnt_d = '0;
                     anim_d     = anim_q + 2'd1;
                  end else begin
                     anim_cnt_d = anim_cnt_q + AW'(1);
                  end
                  y_d = anim_d[0] ? GY_UP : GY;
                  if (!face_q) begin
                     if (nx >= {1'b0, X_MAX}) begin
                        x_d        = X_MAX;
                        state_d    = TURN;
                        turn_cnt_d = '0;
                     end else begin
                        x_d = nx[9:0];
                     end
                  end else begin
                     if (x_q <= {8'b0, speed}) begin
                        x_d        = 10'd0;
                        state_d    = TURN;
                        turn_cnt_d = '0;
                     end else begin
                        x_d = x_q - {8'b0, speed};
                     end
                  end
               end
            end
            TURN: begin
               anim_d = 2'd0;
               y_d    = GY;
               if (turn_cnt_q == TURN_LAST) begin
                  turn_cnt_d = '0;
                  face_d     = ~face_q;
                  state_d    = WALK;
               end else begin
                  turn_cnt_d = turn_cnt_q + TW'(1);
               end
            end
            SPIN: begin
               if (spin_cnt_q == SPIN_LAST) begin
                  face_d     = saved_face_q;
                  spin_d     = 1'b0;
                  y_d        = GY;
                  anim_d     = 2'd0;
                  anim_cnt_d = '0;
                  spin_cnt_d = '0;
                  state_d    = WALK;
               end else begin
                  anim_d = spin_cnt_q[1:0];
                  if (spin_cnt_q[1:0] == 2'd3) face_d = ~face_q;
                  spin_cnt_d = spin_cnt_q + SW'(1);
               end
            end
            default: state_d = WALK;
         endcase
      end
   end

   assign goose_x     = x_q;
   assign goose_y     = y_q;
   assign anim_frame  = anim_q;
   assign facing_left = face_q;
   assign spinning    = spin_q;

endmodule
